// File: rtl/bounded_up_dn_cntr_pkg.sv
// rtl/bounded_up_dn_cntr_pkg.sv - shared state and mode encodings for the bounded up/down counter
package bounded_up_dn_cntr_pkg;

    // Run-control FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cntr_state_e;

    // Boundary behaviour selected by mode_sat
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/bounded_step_calc.sv
// rtl/bounded_step_calc.sv - combinational next-count and boundary-event calculation
module bounded_step_calc
    import bounded_up_dn_cntr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  cnt,
    input  logic [STEP_W-1:0] step,
    input  logic              up_dnb,
    input  logic              mode_sat,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    output logic [WIDTH-1:0]  nxt_cnt,
    output logic              bound_evt
);

    // One extra bit keeps the carry out of an up step and the borrow of a down step visible
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] evt_val;

    assign cnt_ext  = {1'b0, cnt};
    assign step_ext = (WIDTH+1)'(step);
    assign sum      = cnt_ext + step_ext;
    assign diff     = cnt_ext - step_ext;

    // Detect a crossing in the count direction and pick the landing value
    always_comb begin
        bound_evt = 1'b0;
        evt_val   = cnt;
        // A zero step never moves the count, so it can never raise an event
        if (step != '0) begin
            if (up_dnb) begin
                bound_evt = (sum > {1'b0, hi_bound});
            end else begin
                bound_evt = diff[WIDTH] || (diff[WIDTH-1:0] < lo_bound);
            end
        end
        case (mode_sat)
            MODE_SAT:  evt_val = up_dnb ? hi_bound : lo_bound;
            MODE_WRAP: evt_val = up_dnb ? lo_bound : hi_bound;
            default:   evt_val = cnt;
        endcase
        if (bound_evt) begin
            nxt_cnt = evt_val;
        end else begin
            nxt_cnt = up_dnb ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bounded_up_dn_cntr.sv
// rtl/bounded_up_dn_cntr.sv - bounded up/down counter with load and start/stop run control
module bounded_up_dn_cntr
    import bounded_up_dn_cntr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              up_dnb,
    input  logic              mode_sat,
    input  logic              one_shot,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_bound,
    input  logic [WIDTH-1:0]  hi_bound,
    output logic [WIDTH-1:0]  cnt,
    output logic              running,
    output logic              tc,
    output logic              done,
    output logic              cfg_err
);

    cntr_state_e      state;
    cntr_state_e      state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] calc_cnt;
    logic             calc_evt;
    logic             step_en;
    logic             tc_nxt;
    logic             done_nxt;

    assign cfg_err = (lo_bound > hi_bound);
    assign running = (state == ST_RUN);

    // A load always takes precedence over stepping, and an inverted bound pair freezes the count
    assign step_en = (state == ST_RUN) && !load_en && !cfg_err;

    bounded_step_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .cnt       (cnt),
        .step      (step),
        .up_dnb    (up_dnb),
        .mode_sat  (mode_sat),
        .lo_bound  (lo_bound),
        .hi_bound  (hi_bound),
        .nxt_cnt   (calc_cnt),
        .bound_evt (calc_evt)
    );

    // Priority mux for the count and next-state logic for run control
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tc_nxt    = 1'b0;
        done_nxt  = 1'b0;
        if (load_en) begin
            cnt_nxt = load_data;
        end else if (step_en) begin
            cnt_nxt  = calc_cnt;
            tc_nxt   = calc_evt;
            done_nxt = calc_evt && one_shot;
        end
        case (state)
            ST_IDLE: if (start && !stop) state_nxt = ST_RUN;
            ST_RUN:  if (stop || done_nxt) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, count and pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tc    <= tc_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bounded_up_dn_cntr.sv
// tb/tb_bounded_up_dn_cntr.sv - self-checking bench for bounded_up_dn_cntr
module tb_bounded_up_dn_cntr;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       up_dnb = 1'b1;
    logic       mode_sat = 1'b0;
    logic       one_shot = 1'b0;
    logic [3:0] step = 4'd0;
    logic [7:0] lo_bound = 8'd0;
    logic [7:0] hi_bound = 8'd255;
    logic [7:0] cnt;
    logic       running;
    logic       tc;
    logic       done;
    logic       cfg_err;

    always #5 clk = ~clk;

    bounded_up_dn_cntr #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .load_en   (load_en),
        .load_data (load_data),
        .up_dnb    (up_dnb),
        .mode_sat  (mode_sat),
        .one_shot  (one_shot),
        .step      (step),
        .lo_bound  (lo_bound),
        .hi_bound  (hi_bound),
        .cnt       (cnt),
        .running   (running),
        .tc        (tc),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        logic       st;
        logic       sp;
        logic       ld;
        logic [7:0] ldd;
        logic       up;
        logic       sat;
        logic       os;
        logic [3:0] stp;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] e_cnt;
        logic       e_run;
        logic       e_tc;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_cnt;
    bit   m_run;
    bit   m_tc;
    bit   m_done;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic st, input logic sp, input logic ld, input logic [7:0] ldd,
                                input logic up, input logic sat, input logic os, input logic [3:0] stp,
                                input logic [7:0] lo, input logic [7:0] hi,
                                input logic [7:0] ec, input logic er, input logic et, input logic ed);
        vec_t v;
        v.st = st; v.sp = sp; v.ld = ld; v.ldd = ldd;
        v.up = up; v.sat = sat; v.os = os; v.stp = stp;
        v.lo = lo; v.hi = hi;
        v.e_cnt = ec; v.e_run = er; v.e_tc = et; v.e_done = ed;
        v.e_err = (lo > hi);
        vecs.push_back(v);
    endfunction

    task automatic apply(input int idx, input vec_t v);
        start = v.st; stop = v.sp; load_en = v.ld; load_data = v.ldd;
        up_dnb = v.up; mode_sat = v.sat; one_shot = v.os; step = v.stp;
        lo_bound = v.lo; hi_bound = v.hi;
        @(posedge clk);
        #1;
        chk($sformatf("tbl%0d_cnt", idx), int'(cnt), int'(v.e_cnt));
        chk($sformatf("tbl%0d_running", idx), int'(running), int'(v.e_run));
        chk($sformatf("tbl%0d_tc", idx), int'(tc), int'(v.e_tc));
        chk($sformatf("tbl%0d_done", idx), int'(done), int'(v.e_done));
        chk($sformatf("tbl%0d_cfg_err", idx), int'(cfg_err), int'(v.e_err));
    endtask

    // Reference: integer arithmetic straight from the counting rules
    task automatic model_clock();
        int  nx;
        int  st;
        int  lo;
        int  hi;
        bit  evt;
        lo  = int'(lo_bound);
        hi  = int'(hi_bound);
        st  = int'(step);
        evt = 1'b0;
        if (load_en) begin
            m_cnt = int'(load_data);
        end else if (m_run && lo <= hi && st != 0) begin
            if (up_dnb) begin
                nx  = m_cnt + st;
                evt = (nx > hi);
            end else begin
                nx  = m_cnt - st;
                evt = (nx < lo);
            end
            if (!evt)          m_cnt = nx;
            else if (mode_sat) m_cnt = up_dnb ? hi : lo;
            else               m_cnt = up_dnb ? lo : hi;
        end
        m_tc   = evt;
        m_done = evt && one_shot;
        if (!m_run)                m_run = start && !stop;
        else if (stop || m_done)   m_run = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tc", int'(tc), 0);
        chk("rst_done", int'(done), 0);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of RUN
        load_en = 1'b1; load_data = 8'h37;
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_cnt", int'(cnt), 8'h37);
        chk("pre_rst_running", int'(running), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cnt", int'(cnt), 0);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_tc", int'(tc), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Up, wrap, lo=10 hi=20 step=3
        add(0,0,1,18, 1,0,0,3, 10,20,  18,0,0,0);
        add(1,0,0,0,  1,0,0,3, 10,20,  18,1,0,0);
        add(0,0,0,0,  1,0,0,3, 10,20,  10,1,1,0);
        add(0,0,0,0,  1,0,0,3, 10,20,  13,1,0,0);
        add(0,0,0,0,  1,0,0,3, 10,20,  16,1,0,0);
        add(0,0,0,0,  1,0,0,3, 10,20,  19,1,0,0);
        add(0,0,0,0,  1,0,0,3, 10,20,  10,1,1,0);
        add(0,1,0,0,  1,0,0,3, 10,20,  13,0,0,0);
        // Down, saturate, step=5: repeated tc at the bound
        add(0,0,1,12, 0,1,0,5, 10,20,  12,0,0,0);
        add(1,0,0,0,  0,1,0,5, 10,20,  12,1,0,0);
        add(0,0,0,0,  0,1,0,5, 10,20,  10,1,1,0);
        add(0,0,0,0,  0,1,0,5, 10,20,  10,1,1,0);
        add(0,1,0,0,  0,1,0,5, 10,20,  10,0,1,0);
        // One-shot up to full scale
        add(0,0,1,250, 1,1,1,4, 0,255, 250,0,0,0);
        add(1,0,0,0,   1,1,1,4, 0,255, 250,1,0,0);
        add(0,0,0,0,   1,1,1,4, 0,255, 254,1,0,0);
        add(0,0,0,0,   1,1,1,4, 0,255, 255,0,1,1);
        add(0,0,0,0,   1,1,1,4, 0,255, 255,0,0,0);
        // start+stop together, load during RUN, step=0, count outside bounds, borrow below zero
        add(1,1,0,0,   1,0,0,0, 0,255, 255,0,0,0);
        add(1,0,0,0,   1,0,0,0, 0,255, 255,1,0,0);
        add(0,0,1,5,   1,0,0,0, 0,255, 5,1,0,0);
        add(0,0,0,0,   1,0,0,0, 0,3,   5,1,0,0);
        add(0,0,0,0,   1,0,0,1, 0,3,   0,1,1,0);
        add(1,0,0,0,   0,0,0,4, 0,3,   3,1,1,0);
        add(0,1,0,0,   0,0,0,0, 0,3,   3,0,0,0);
        // Inverted bounds freeze RUN, load still works
        add(1,0,0,0,   1,0,0,3, 30,20, 3,1,0,0);
        add(0,0,0,0,   1,0,0,3, 30,20, 3,1,0,0);
        add(0,0,1,7,   1,0,0,3, 30,20, 7,1,0,0);
        add(0,1,0,0,   1,0,0,3, 30,20, 7,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Randomized run against the reference model
        start = 1'b0; stop = 1'b0; load_en = 1'b0;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        m_cnt = 0; m_run = 1'b0; m_tc = 1'b0; m_done = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 500; i++) begin
            if (i % 25 == 0) begin
                lo_bound = 8'($urandom_range(0, 120));
                hi_bound = 8'($urandom_range(40, 255));
            end
            if (i % 8 == 0) begin
                up_dnb   = 1'($urandom);
                mode_sat = 1'($urandom);
            end
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 15) == 0);
            load_en   = ($urandom_range(0, 19) == 0);
            load_data = 8'($urandom);
            one_shot  = ($urandom_range(0, 3) == 0);
            step      = 4'($urandom);
            model_clock();
            @(posedge clk);
            #1;
            chk("rnd_cnt", int'(cnt), m_cnt);
            chk("rnd_running", int'(running), int'(m_run));
            chk("rnd_tc", int'(tc), int'(m_tc));
            chk("rnd_done", int'(done), int'(m_done));
            chk("rnd_cfg_err", int'(cfg_err), int'(lo_bound > hi_bound));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
